// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and the read-return owner encoding for the BRAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_AW        = 16;
  localparam int DEFAULT_DW        = 16;
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_CORE = 2'b01,
    RD_LD   = 2'b10
  } rd_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port BRAM between the core and the program loader,
// bounding the core's wait to MAX_BURST loader grants and routing read data back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = DEFAULT_AW,
  parameter int DW        = DEFAULT_DW,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int            BW        = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt_r;
  logic [BW-1:0] burst_cnt_s;
  rd_owner_t     rd_owner_r;
  rd_owner_t     rd_owner_s;
  logic          core_win_s;
  logic          ld_win_s;

  // Loader wins by default; the core wins alone or once the loader has used up its burst.
  assign core_win_s = core_req & (~ld_req | (burst_cnt_r == BURST_MAX));
  assign ld_win_s   = ld_req & ~core_win_s;

  // State register: burst counter and owner of the read data arriving next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_r <= {BW{1'b0}};
      rd_owner_r  <= RD_NONE;
    end else begin
      burst_cnt_r <= burst_cnt_s;
      rd_owner_r  <= rd_owner_s;
    end
  end

  // Next-state logic for the burst counter and read-return owner.
  always_comb begin
    burst_cnt_s = burst_cnt_r;
    rd_owner_s  = RD_NONE;
    if (!core_req || core_win_s) begin
      burst_cnt_s = {BW{1'b0}};
    end else if (ld_win_s && (burst_cnt_r != BURST_MAX)) begin
      burst_cnt_s = burst_cnt_r + BW'(1);
    end else begin
      burst_cnt_s = burst_cnt_r;
    end
    if (core_win_s && !core_we) begin
      rd_owner_s = RD_CORE;
    end else if (ld_win_s && !ld_we) begin
      rd_owner_s = RD_LD;
    end else begin
      rd_owner_s = RD_NONE;
    end
  end

  // Output logic: grant/memory mux from the winner, read data steered by the owner register.
  always_comb begin
    core_gnt    = core_win_s;
    ld_gnt      = ld_win_s;
    core_stall  = core_req & ~core_win_s;
    mem_en      = core_win_s | ld_win_s;
    mem_wea     = 1'b0;
    mem_addr    = {AW{1'b0}};
    mem_din     = {DW{1'b0}};
    core_rvalid = 1'b0;
    ld_rvalid   = 1'b0;
    core_rdata  = {DW{1'b0}};
    ld_rdata    = {DW{1'b0}};
    if (core_win_s) begin
      mem_wea  = core_we;
      mem_addr = core_addr;
      mem_din  = core_wdata;
    end else if (ld_win_s) begin
      mem_wea  = ld_we;
      mem_addr = ld_addr;
      mem_din  = ld_wdata;
    end else begin
      mem_wea  = 1'b0;
      mem_addr = {AW{1'b0}};
      mem_din  = {DW{1'b0}};
    end
    case (rd_owner_r)
      RD_CORE: begin
        core_rvalid = 1'b1;
        core_rdata  = mem_dout;
      end
      RD_LD: begin
        ld_rvalid = 1'b1;
        ld_rdata  = mem_dout;
      end
      default: begin
        core_rvalid = 1'b0;
        ld_rvalid   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural model predicts every cycle's
// grants, memory drive and read returns; a negedge monitor compares against the DUT.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [15:0] core_addr = 16'h0000, core_wdata = 16'h0000;
  logic        core_gnt, core_rvalid, core_stall;
  logic [15:0] core_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = 16'h0000, ld_wdata = 16'h0000;
  logic        ld_gnt, ld_rvalid;
  logic [15:0] ld_rdata;
  logic        mem_en, mem_wea;
  logic [15:0] mem_addr, mem_din;
  logic [15:0] mem_dout = 16'h0000;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257 + 16'h3C00);
  endfunction

  // Synchronous 1-cycle-latency BRAM, preloaded with init_val.
  logic [15:0] bram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_wea) bram[mem_addr[7:0]] = mem_din;
        else         mem_dout = bram[mem_addr[7:0]];
      end
    end
  end

  typedef struct packed {
    logic        cg, lg, stall, en, wea;
    logic [15:0] addr, din;
    logic        crv;
    logic [15:0] crd;
    logic        lrv;
    logic [15:0] lrd;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state: memory contents, core wait length, pending read return.
  logic [15:0] ref_mem [0:255];
  int          wait_cnt = 0;
  int          pend_owner = 0;
  logic [15:0] pend_data = 16'h0000;

  // Outstanding requests (held until the model says they were granted).
  bit          c_pend = 1'b0, c_wr = 1'b0, l_pend = 1'b0, l_wr = 1'b0;
  logic [15:0] c_a = 16'h0000, c_d = 16'h0000, l_a = 16'h0000, l_d = 16'h0000;
  bit          refill = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic serve(input bit wr, input logic [15:0] a, input logic [15:0] d, input int owner);
    if (wr) begin
      ref_mem[a[7:0]] = d;
    end else begin
      pend_owner = owner;
      pend_data  = ref_mem[a[7:0]];
    end
  endtask

  task automatic tick(input bit rst_cyc);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = ~rst_cyc;
    core_req   = c_pend & ~rst_cyc;
    core_we    = c_wr;
    core_addr  = c_a;
    core_wdata = c_d;
    ld_req     = l_pend & ~rst_cyc;
    ld_we      = l_wr;
    ld_addr    = l_a;
    ld_wdata   = l_d;
    e = '0;
    if (rst_cyc) begin
      pend_owner = 0;
      wait_cnt   = 0;
    end else begin
      e.crv = (pend_owner == 1);
      e.crd = e.crv ? pend_data : 16'h0000;
      e.lrv = (pend_owner == 2);
      e.lrd = e.lrv ? pend_data : 16'h0000;
      e.cg    = core_req && (!ld_req || wait_cnt >= MAXB);
      e.lg    = ld_req && !e.cg;
      e.stall = core_req && !e.cg;
      wait_cnt   = e.stall ? wait_cnt + 1 : 0;
      pend_owner = 0;
      if (e.cg) begin
        e.en = 1'b1; e.wea = c_wr; e.addr = c_a; e.din = c_d;
        serve(c_wr, c_a, c_d, 1);
        c_pend = refill;
        if (refill) begin c_wr = 1'b0; c_a = 16'($urandom_range(0, 15)); end
      end else if (e.lg) begin
        e.en = 1'b1; e.wea = l_wr; e.addr = l_a; e.din = l_d;
        serve(l_wr, l_a, l_d, 2);
        l_pend = refill;
        if (refill) begin l_wr = 1'b0; l_a = 16'($urandom_range(16, 31)); end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic core_go(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    c_pend = 1'b1; c_wr = wr; c_a = a; c_d = d;
    n = 0;
    while (c_pend && n < 20) begin tick(1'b0); n++; end
    if (c_pend) begin
      chk("core_grant_timeout", 16'd1, 16'd0);
      c_pend = 1'b0;
    end
  endtask

  task automatic ld_go(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    l_pend = 1'b1; l_wr = wr; l_a = a; l_d = d;
    n = 0;
    while (l_pend && n < 20) begin tick(1'b0); n++; end
    if (l_pend) begin
      chk("ld_grant_timeout", 16'd1, 16'd0);
      l_pend = 1'b0;
    end
  endtask

  // Monitor: compares each cycle's DUT outputs against the queued expectation.
  exp_t m;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("core_gnt",    16'(core_gnt),    16'(m.cg));
      chk("ld_gnt",      16'(ld_gnt),      16'(m.lg));
      chk("core_stall",  16'(core_stall),  16'(m.stall));
      chk("mem_en",      16'(mem_en),      16'(m.en));
      chk("mem_wea",     16'(mem_wea),     16'(m.wea));
      chk("mem_addr",    mem_addr,         m.addr);
      chk("mem_din",     mem_din,          m.din);
      chk("core_rvalid", 16'(core_rvalid), 16'(m.crv));
      chk("core_rdata",  core_rdata,       m.crd);
      chk("ld_rvalid",   16'(ld_rvalid),   16'(m.lrv));
      chk("ld_rdata",    ld_rdata,         m.lrd);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    tick(1'b1);
    tick(1'b1);
    // first core read after reset release, then loader write and core read-back
    core_go(1'b0, 16'h0010, 16'h0000);
    tick(1'b0);
    ld_go(1'b1, 16'h0020, 16'h1234);
    tick(1'b0);
    core_go(1'b0, 16'h0020, 16'h0000);
    tick(1'b0);
    // back-to-back core reads
    core_go(1'b0, 16'h0001, 16'h0000);
    core_go(1'b0, 16'h0002, 16'h0000);
    core_go(1'b0, 16'h0003, 16'h0000);
    tick(1'b0);
    // reset arriving the cycle after a read grant drops the return
    core_go(1'b0, 16'h0030, 16'h0000);
    tick(1'b1);
    tick(1'b1);
    core_go(1'b0, 16'h0030, 16'h0000);
    tick(1'b0);
    // idle
    repeat (10) tick(1'b0);
    // sustained contention: MAXB loader grants then one core grant, repeating
    refill = 1'b1;
    c_pend = 1'b1; c_wr = 1'b0; c_a = 16'h0005;
    l_pend = 1'b1; l_wr = 1'b0; l_a = 16'h0011;
    repeat (16) tick(1'b0);
    refill = 1'b0;
    n = 0;
    while ((c_pend || l_pend) && n < 20) begin tick(1'b0); n++; end
    if (c_pend || l_pend) chk("contention_drain_timeout", 16'd1, 16'd0);
    // randomized mixed traffic
    for (int k = 0; k < 300; k++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1; c_wr = 1'($urandom_range(0, 1));
        c_a = 16'($urandom_range(0, 15)); c_d = 16'($urandom);
      end
      if (!l_pend && $urandom_range(0, 2) != 0) begin
        l_pend = 1'b1; l_wr = 1'($urandom_range(0, 1));
        l_a = 16'($urandom_range(0, 15)); l_d = 16'($urandom);
      end
      tick(1'b0);
    end
    c_pend = 1'b0;
    l_pend = 1'b0;
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
